proc_io_bridge: RTL and testbench
=================================

// Module: proc_io_bridge
// PURPOSE
// Port controller between the filter soft-processor and external sample streams. Buffers one
// sample per input port and serves it when the processor raises req_in; collects processor
// writes (out_en) into a tagged output FIFO drained by a valid/ready sink. Replaces bench-side
// port decoding in synthesizable designs; sits directly beside the processor instance.
// PARAMETERS
// NUBITS  23  data width (signed two's complement, processor word)
// NUI      1  number of input ports (width of proc_req_in)
// NUO      2  number of output ports (width of proc_out_en)
// DEPTH    8  output FIFO depth, power of two >= 2
// TAGW     1  port tag width, = max(1,clog2(NUO))
// PORTS
// clk           in   1            clock, all state on rising edge
// rst           in   1            asynchronous, active-low reset
// proc_req_in   in   NUI          one-hot read request from processor
// proc_io_in    out  NUBITS       data to processor (combinational)
// proc_out_en   in   NUO          one-hot write enable from processor
// proc_io_out   in   NUBITS       data from processor
// s_in_data     in   NUI*NUBITS   input stream data, port k at [k*NUBITS +: NUBITS]
// s_in_valid    in   NUI          input stream valid per port
// s_in_ready    out  NUI          input stream ready per port
// m_out_data    out  NUBITS       FIFO head data
// m_out_tag     out  TAGW         FIFO head port index
// m_out_valid   out  1            FIFO not empty
// m_out_ready   in   1            sink accepts head
// fifo_level    out  clog2(DEPTH)+1 current FIFO occupancy
// err_under     out  NUI          sticky: read of empty input port
// err_over      out  1            sticky: write to full FIFO dropped
// clr_err       in   1            synchronous clear of sticky flags
// BEHAVIOUR
// - Reset (rst=0, async): hold regs=0, all full flags=0, FIFO empty, fifo_level=0,
//   err_*=0, s_in_ready=all 1, m_out_valid=0, m_out_data/tag=0.
// - Input port k: hold reg + full bit. s_in_ready[k] = ~full[k] | sel[k]; sel = lowest set bit
//   of proc_req_in. Load on s_in_valid&s_in_ready (full<=1); else clear full on sel[k].
//   Consume and refill in same cycle: new data loaded, full stays 1.
// - proc_io_in = hold[sel] same cycle as req_in (zero latency); 0 when proc_req_in==0.
//   Multiple req bits: lowest index served/consumed, others ignored (no state change).
// - Read of empty port: proc_io_in = stale hold value, err_under[k]<=1, no state change.
// - Output: on any proc_out_en bit, push {index of lowest set bit, proc_io_out}; visible at
//   m_out_* next cycle earliest (1-cycle latency into empty FIFO, no fall-through).
// - Pop when m_out_valid & m_out_ready. Push+pop same cycle: both occur, level unchanged,
//   including when full (no overflow). Push when full without pop: data dropped, err_over<=1.
// - Pointers wrap modulo DEPTH; level range 0..DEPTH.
// - clr_err clears flags; an error event in the same cycle wins (flag stays/sets 1).
// - Data passes unmodified: no sign extension, no saturation.
// - Reset mid-operation: buffered input and FIFO contents discarded immediately.
// STRUCTURE
// - proc_io_defs.vh: NUBITS default, TAGW/level width macros, clog2 function.
// - Sub-module sync_fifo (WIDTH=TAGW+NUBITS, DEPTH): registered head, level, full/empty.
// - Top: NUI hold-reg slices (generate), priority encoders for req_in/out_en, error flags.
// TESTING
// - Reset mid-stream with FIFO holding 3 entries -> level=0, m_out_valid=0, s_in_ready=all 1.
// - Load port0 with -5, raise req_in=1 -> proc_io_in=-5 same cycle, full clears; s_in_valid
//   held with 7 same cycle -> full stays 1, next read gives 7.
// - req_in=1 with port empty -> proc_io_in=last value, err_under[0]=1; clr_err -> 0.
// - out_en=2'b10 data 4194303, then 2'b01 data -4194304 -> FIFO emits tag1/4194303 then
//   tag0/-4194304 in order; out_en=2'b11 data 9 -> single entry, tag0.
// - m_out_ready=0, push 9 values with DEPTH=8 -> level=8, 9th dropped, err_over=1; then push+pop
//   same cycle at full -> level 8, no new error.
// - Random valid/ready and req/out_en traffic vs. reference model for 10k cycles -> no loss,
//   no duplication, order preserved per tag.

Source files
------------

// File: rtl/proc_io_bridge_pkg.sv
// Shared sizing for the processor I/O bridge: default word/port/FIFO geometry and
// the index-width helper used for the output port tag and FIFO level.
package proc_io_bridge_pkg;
  localparam int NUBITS = 23;
  localparam int NUI    = 1;
  localparam int NUO    = 2;
  localparam int DEPTH  = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TAGW = idx_w(NUO);
  localparam int LVLW = $clog2(DEPTH) + 1;
endpackage

// File: rtl/proc_io_bridge_sync_fifo.sv
// Synchronous FIFO for tagged processor writes. Head is read from storage registers,
// so a pushed entry appears one cycle later; push+pop at full is accepted.
module proc_io_bridge_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full       = (level == (AW+1)'(DEPTH));
  assign head_valid = (level != '0);
  assign do_pop     = head_valid & pop_ready;
  // a pop in the same cycle frees the slot, so a push at full is still accepted
  assign do_push    = push & (~full | do_pop);
  assign drop       = push & full & ~do_pop;
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/proc_io_bridge.sv
// Port controller beside the filter soft-processor: one-deep hold buffer per input
// stream served on req_in, and a tagged output FIFO fed by out_en writes.
module proc_io_bridge
  import proc_io_bridge_pkg::*;
#(
  parameter int NUBITS = proc_io_bridge_pkg::NUBITS,
  parameter int NUI    = proc_io_bridge_pkg::NUI,
  parameter int NUO    = proc_io_bridge_pkg::NUO,
  parameter int DEPTH  = proc_io_bridge_pkg::DEPTH,
  parameter int TAGW   = idx_w(NUO)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUI-1:0]          proc_req_in,
  output logic [NUBITS-1:0]       proc_io_in,
  input  logic [NUO-1:0]          proc_out_en,
  input  logic [NUBITS-1:0]       proc_io_out,
  input  logic [NUI*NUBITS-1:0]   s_in_data,
  input  logic [NUI-1:0]          s_in_valid,
  output logic [NUI-1:0]          s_in_ready,
  output logic [NUBITS-1:0]       m_out_data,
  output logic [TAGW-1:0]         m_out_tag,
  output logic                    m_out_valid,
  input  logic                    m_out_ready,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [NUI-1:0]          err_under,
  output logic                    err_over,
  input  logic                    clr_err
);
  logic [NUBITS-1:0] hold [NUI];
  logic [NUI-1:0]    full;
  logic [NUI-1:0]    sel;
  logic [TAGW-1:0]   out_tag;
  logic              drop;

  // only the lowest requested port is served; higher request bits are ignored
  assign sel        = proc_req_in & (~proc_req_in + NUI'(1));
  assign s_in_ready = ~full | sel;

  always_comb begin
    proc_io_in = '0;
    for (int k = 0; k < NUI; k++) begin
      if (sel[k]) proc_io_in = hold[k];
    end
  end

  for (genvar k = 0; k < NUI; k++) begin : g_in
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold[k] <= '0;
        full[k] <= 1'b0;
      end else if (s_in_valid[k] && s_in_ready[k]) begin
        hold[k] <= s_in_data[k*NUBITS +: NUBITS];
        full[k] <= 1'b1;
      end else if (sel[k]) begin
        full[k] <= 1'b0;
      end
    end
  end

  always_comb begin
    out_tag = '0;
    for (int k = NUO - 1; k >= 0; k--) begin
      if (proc_out_en[k]) out_tag = TAGW'(k);
    end
  end

  proc_io_bridge_sync_fifo #(
    .WIDTH (TAGW + NUBITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (|proc_out_en),
    .push_data  ({out_tag, proc_io_out}),
    .pop_ready  (m_out_ready),
    .head_data  ({m_out_tag, m_out_data}),
    .head_valid (m_out_valid),
    .level      (fifo_level),
    .drop       (drop)
  );

  // an error event in the same cycle as clr_err leaves the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_under <= '0;
      err_over  <= 1'b0;
    end else begin
      err_under <= (err_under & ~{NUI{clr_err}}) | (sel & ~full);
      err_over  <= (err_over & ~clr_err) | drop;
    end
  end
endmodule

// File: tb/tb_proc_io_bridge.sv
// Self-checking bench for proc_io_bridge: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_proc_io_bridge;
  import proc_io_bridge_pkg::*;

  localparam int W = TAGW + NUBITS;

  logic                  clk;
  logic                  rst;
  logic [NUI-1:0]        proc_req_in;
  logic [NUBITS-1:0]     proc_io_in;
  logic [NUO-1:0]        proc_out_en;
  logic [NUBITS-1:0]     proc_io_out;
  logic [NUI*NUBITS-1:0] s_in_data;
  logic [NUI-1:0]        s_in_valid;
  logic [NUI-1:0]        s_in_ready;
  logic [NUBITS-1:0]     m_out_data;
  logic [TAGW-1:0]       m_out_tag;
  logic                  m_out_valid;
  logic                  m_out_ready;
  logic [LVLW-1:0]       fifo_level;
  logic [NUI-1:0]        err_under;
  logic                  err_over;
  logic                  clr_err;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic [NUBITS-1:0] hold_m [NUI];
  bit                full_m [NUI];
  logic [W-1:0]      q_m [$];
  logic [NUI-1:0]    eu_m;
  bit                eo_m;

  proc_io_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .proc_req_in (proc_req_in),
    .proc_io_in  (proc_io_in),
    .proc_out_en (proc_out_en),
    .proc_io_out (proc_io_out),
    .s_in_data   (s_in_data),
    .s_in_valid  (s_in_valid),
    .s_in_ready  (s_in_ready),
    .m_out_data  (m_out_data),
    .m_out_tag   (m_out_tag),
    .m_out_valid (m_out_valid),
    .m_out_ready (m_out_ready),
    .fifo_level  (fifo_level),
    .err_under   (err_under),
    .err_over    (err_over),
    .clr_err     (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    proc_req_in = '0;
    proc_out_en = '0;
    proc_io_out = '0;
    s_in_data   = '0;
    s_in_valid  = '0;
    m_out_ready = 1'b0;
    clr_err     = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #3;
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", m_out_valid); end
    checks++; if (s_in_ready !== '1) begin errors++; $display("FAIL reset_ready got %b want all 1", s_in_ready); end
    checks++; if ({m_out_tag, m_out_data} !== '0) begin errors++; $display("FAIL reset_head got %h want 0", {m_out_tag, m_out_data}); end
    checks++; if ({err_under, err_over} !== '0) begin errors++; $display("FAIL reset_err got %b want 0", {err_under, err_over}); end
    checks++; if (proc_io_in !== '0) begin errors++; $display("FAIL reset_io_in got %h want 0", proc_io_in); end
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
  endtask

  task automatic test_input_port();
    s_in_valid = 1'b1; s_in_data = NUBITS'(-5);
    tick();
    s_in_valid = 1'b0;
    #1;
    checks++; if (s_in_ready[0] !== 1'b0) begin errors++; $display("FAIL load_ready got %b want 0", s_in_ready[0]); end
    proc_req_in = 1'b1; s_in_valid = 1'b1; s_in_data = NUBITS'(7);
    #1;
    checks++; if (proc_io_in !== NUBITS'(-5)) begin errors++; $display("FAIL read_m5 got %h want %h", proc_io_in, NUBITS'(-5)); end
    checks++; if (s_in_ready[0] !== 1'b1) begin errors++; $display("FAIL read_ready got %b want 1", s_in_ready[0]); end
    tick();
    proc_req_in = '0; s_in_valid = 1'b0;
    #1;
    checks++; if (s_in_ready[0] !== 1'b0) begin errors++; $display("FAIL refill_full got ready %b want 0", s_in_ready[0]); end
    proc_req_in = 1'b1;
    #1;
    checks++; if (proc_io_in !== NUBITS'(7)) begin errors++; $display("FAIL read_7 got %h want 7", proc_io_in); end
    tick();
    proc_req_in = '0;
    #1;
    checks++; if (s_in_ready[0] !== 1'b1) begin errors++; $display("FAIL consumed_ready got %b want 1", s_in_ready[0]); end
    checks++; if (err_under !== '0) begin errors++; $display("FAIL no_under got %b want 0", err_under); end
  endtask

  task automatic test_underflow();
    proc_req_in = 1'b1;
    #1;
    checks++; if (proc_io_in !== NUBITS'(7)) begin errors++; $display("FAIL stale_val got %h want 7", proc_io_in); end
    tick();
    proc_req_in = '0;
    #1;
    checks++; if (err_under[0] !== 1'b1) begin errors++; $display("FAIL under_set got %b want 1", err_under[0]); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (err_under[0] !== 1'b0) begin errors++; $display("FAIL under_clr got %b want 0", err_under[0]); end
    proc_req_in = 1'b1; clr_err = 1'b1;
    tick();
    proc_req_in = '0; clr_err = 1'b0;
    checks++; if (err_under[0] !== 1'b1) begin errors++; $display("FAIL under_wins got %b want 1", err_under[0]); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_output_order();
    m_out_ready = 1'b0;
    proc_out_en = 2'b10; proc_io_out = NUBITS'(4194303);
    #1;
    checks++; if (m_out_valid !== 1'b0) begin errors++; $display("FAIL no_fallthrough got %b want 0", m_out_valid); end
    tick();
    proc_out_en = 2'b01; proc_io_out = NUBITS'(-4194304);
    tick();
    proc_out_en = 2'b11; proc_io_out = NUBITS'(9);
    tick();
    proc_out_en = '0;
    checks++; if (fifo_level !== LVLW'(3)) begin errors++; $display("FAIL order_level got %0d want 3", fifo_level); end
    m_out_ready = 1'b1;
    checks++; if ({m_out_tag, m_out_data} !== {TAGW'(1), NUBITS'(4194303)}) begin errors++; $display("FAIL order_0 got %h want %h", {m_out_tag, m_out_data}, {TAGW'(1), NUBITS'(4194303)}); end
    tick();
    checks++; if ({m_out_tag, m_out_data} !== {TAGW'(0), NUBITS'(-4194304)}) begin errors++; $display("FAIL order_1 got %h want %h", {m_out_tag, m_out_data}, {TAGW'(0), NUBITS'(-4194304)}); end
    tick();
    checks++; if ({m_out_tag, m_out_data} !== {TAGW'(0), NUBITS'(9)}) begin errors++; $display("FAIL order_2 got %h want %h", {m_out_tag, m_out_data}, {TAGW'(0), NUBITS'(9)}); end
    tick();
    m_out_ready = 1'b0;
    checks++; if (m_out_valid !== 1'b0 || fifo_level !== '0) begin errors++; $display("FAIL order_empty got valid %b level %0d want 0 0", m_out_valid, fifo_level); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp;
    m_out_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      proc_out_en = 2'b01; proc_io_out = NUBITS'(i);
      tick();
    end
    proc_out_en = '0;
    checks++; if (fifo_level !== LVLW'(DEPTH) || err_over !== 1'b0) begin errors++; $display("FAIL fill got level %0d err %b want %0d 0", fifo_level, err_over, DEPTH); end
    proc_out_en = 2'b01; proc_io_out = NUBITS'(DEPTH + 1);
    tick();
    proc_out_en = '0;
    checks++; if (fifo_level !== LVLW'(DEPTH) || err_over !== 1'b1) begin errors++; $display("FAIL overflow got level %0d err %b want %0d 1", fifo_level, err_over, DEPTH); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++; if (err_over !== 1'b0) begin errors++; $display("FAIL over_clr got %b want 0", err_over); end
    proc_out_en = 2'b10; proc_io_out = NUBITS'(100); m_out_ready = 1'b1;
    tick();
    proc_out_en = '0; m_out_ready = 1'b0;
    checks++; if (fifo_level !== LVLW'(DEPTH) || err_over !== 1'b0) begin errors++; $display("FAIL pushpop_full got level %0d err %b want %0d 0", fifo_level, err_over, DEPTH); end
    m_out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp = (i < DEPTH - 1) ? {TAGW'(0), NUBITS'(i + 2)} : {TAGW'(1), NUBITS'(100)};
      checks++; if ({m_out_tag, m_out_data} !== exp) begin errors++; $display("FAIL drain_%0d got %h want %h", i, {m_out_tag, m_out_data}, exp); end
      tick();
    end
    m_out_ready = 1'b0;
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL drain_level got %0d want 0", fifo_level); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      proc_out_en = 2'b01; proc_io_out = NUBITS'(20 + i);
      s_in_valid = 1'b1; s_in_data = NUBITS'(11);
      tick();
    end
    idle();
    checks++; if (fifo_level !== LVLW'(3) || s_in_ready !== '0) begin errors++; $display("FAIL pre_rst got level %0d ready %b want 3 0", fifo_level, s_in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (fifo_level !== '0 || m_out_valid !== 1'b0 || s_in_ready !== '1) begin errors++; $display("FAIL mid_rst got level %0d valid %b ready %b want 0 0 all1", fifo_level, m_out_valid, s_in_ready); end
    rst = 1'b1;
    tick();
  endtask

  task automatic model_clear();
    for (int k = 0; k < NUI; k++) begin hold_m[k] = '0; full_m[k] = 0; end
    q_m.delete();
    eu_m = '0;
    eo_m = 0;
  endtask

  task automatic test_random();
    int           idx;
    int           oidx;
    int           sz;
    int           fails_shown;
    bit           pop;
    logic [W-1:0] head;
    logic [NUBITS-1:0] exp_in;
    logic [NUI-1:0]    exp_rdy;
    fails_shown = 0;
    idle();
    rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    model_clear();
    for (int c = 0; c < 10000; c++) begin
      proc_req_in = ($urandom_range(0, 3) == 0) ? NUI'($urandom) : '0;
      proc_out_en = ($urandom_range(0, 2) == 0) ? NUO'($urandom) : '0;
      proc_io_out = NUBITS'($urandom);
      s_in_valid  = NUI'($urandom);
      for (int k = 0; k < NUI; k++) s_in_data[k*NUBITS +: NUBITS] = NUBITS'($urandom);
      m_out_ready = ($urandom_range(0, 3) < (c / 500) % 5);
      clr_err     = ($urandom_range(0, 31) == 0);
      #2;
      idx = -1;
      for (int k = 0; k < NUI; k++) if (idx < 0 && proc_req_in[k]) idx = k;
      exp_in = (idx >= 0) ? hold_m[idx] : '0;
      for (int k = 0; k < NUI; k++) exp_rdy[k] = !full_m[k] || (idx == k);
      sz   = q_m.size();
      head = (sz > 0) ? q_m[0] : '0;
      checks++; if (proc_io_in !== exp_in) begin errors++; if (fails_shown++ < 20) $display("FAIL rnd_io_in c=%0d got %h want %h", c, proc_io_in, exp_in); end
      checks++; if (s_in_ready !== exp_rdy) begin errors++; if (fails_shown++ < 20) $display("FAIL rnd_ready c=%0d got %b want %b", c, s_in_ready, exp_rdy); end
      checks++; if (m_out_valid !== (sz > 0)) begin errors++; if (fails_shown++ < 20) $display("FAIL rnd_valid c=%0d got %b want %b", c, m_out_valid, sz > 0); end
      checks++; if ({m_out_tag, m_out_data} !== head) begin errors++; if (fails_shown++ < 20) $display("FAIL rnd_head c=%0d got %h want %h", c, {m_out_tag, m_out_data}, head); end
      checks++; if (fifo_level !== LVLW'(sz)) begin errors++; if (fails_shown++ < 20) $display("FAIL rnd_level c=%0d got %0d want %0d", c, fifo_level, sz); end
      checks++; if (err_under !== eu_m || err_over !== eo_m) begin errors++; if (fails_shown++ < 20) $display("FAIL rnd_err c=%0d got %b/%b want %b/%b", c, err_under, err_over, eu_m, eo_m); end
      // model next state
      if (clr_err) begin eu_m = '0; eo_m = 0; end
      if (idx >= 0 && !full_m[idx]) eu_m[idx] = 1'b1;
      for (int k = 0; k < NUI; k++) begin
        if (s_in_valid[k] && exp_rdy[k]) begin
          hold_m[k] = s_in_data[k*NUBITS +: NUBITS];
          full_m[k] = 1;
        end else if (idx == k) begin
          full_m[k] = 0;
        end
      end
      pop = (sz > 0) && m_out_ready;
      if (pop) void'(q_m.pop_front());
      if (proc_out_en != '0) begin
        oidx = -1;
        for (int k = 0; k < NUO; k++) if (oidx < 0 && proc_out_en[k]) oidx = k;
        if (sz < DEPTH || pop) q_m.push_back({TAGW'(oidx), proc_io_out});
        else eo_m = 1;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_input_port();
    test_underflow();
    test_output_order();
    test_overflow();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
